// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and load/store.
// Data has priority, a starvation counter forces fetch through, and misaligned or timed-out accesses report errors.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   logic [1:0]  state_r;
   logic [3:0]  starve_cnt_r;
   logic [7:0]  tmo_cnt_r;
   logic        win_data_r;
   logic [1:0]  ofs_r;
   logic [1:0]  size_r;
   logic        uns_r;

   logic        any_req_s;
   logic        d_win_s;
   logic [31:0] sel_addr_s;
   logic [1:0]  sel_size_s;
   logic        sel_we_s;
   logic        misalign_s;
   logic [3:0]  be_s;
   logic [31:0] lane_wdata_s;
   logic [3:0]  starve_nxt_s;
   logic [31:0] resp_rdata_s;

   // Stores enable only the addressed lanes; loads and fetches always read the whole word.
   function automatic logic [3:0] byte_en(input logic we, input logic [1:0] size, input logic [1:0] ofs);
      logic [3:0] be;
      be = 4'b1111;
      if (we) begin
         case (size)
            2'b01:   be = 4'b0001 << ofs;
            2'b10:   be = 4'b0011 << ofs;
            default: be = 4'b1111;
         endcase
      end else begin
         be = 4'b1111;
      end
      return be;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic uns, input logic [1:0] ofs);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rdata[{ofs, 3'b000} +: 8];
      h = ofs[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         2'b01:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b10:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Arbitration decision, alignment check and lane formatting for the request seen in IDLE
   always_comb begin
      any_req_s = d_req | if_req;
      if (d_req && (!if_req || (starve_cnt_r < STARVE_MAX))) begin
         d_win_s = 1'b1;
      end else begin
         d_win_s = 1'b0;
      end
      if (d_win_s) begin
         sel_addr_s = d_addr;
         sel_size_s = d_size;
         sel_we_s   = d_we;
      end else begin
         sel_addr_s = if_addr;
         sel_size_s = 2'b11;
         sel_we_s   = 1'b0;
      end
      case (sel_size_s)
         2'b00:   misalign_s = 1'b1;
         2'b01:   misalign_s = 1'b0;
         2'b10:   misalign_s = sel_addr_s[0];
         2'b11:   misalign_s = |sel_addr_s[1:0];
         default: misalign_s = 1'b1;
      endcase
      be_s = byte_en(sel_we_s, sel_size_s, sel_addr_s[1:0]);
      if (sel_we_s) begin
         case (d_size)
            2'b01:   lane_wdata_s = {4{d_wdata[7:0]}};
            2'b10:   lane_wdata_s = {2{d_wdata[15:0]}};
            default: lane_wdata_s = d_wdata;
         endcase
      end else begin
         lane_wdata_s = 32'd0;
      end
      // Saturating count of data grants taken while fetch was waiting.
      if (if_req && d_win_s) begin
         starve_nxt_s = (starve_cnt_r == 4'hF) ? starve_cnt_r : starve_cnt_r + 4'd1;
      end else begin
         starve_nxt_s = 4'd0;
      end
      if (mem_we) begin
         resp_rdata_s = 32'd0;
      end else begin
         resp_rdata_s = load_extract(mem_rdata, size_r, uns_r, ofs_r);
      end
   end

   // Access sequencing through IDLE, GRANT and RESP with registered port and response outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         starve_cnt_r <= 4'd0;
         tmo_cnt_r    <= 8'd0;
         win_data_r   <= 1'b0;
         ofs_r        <= 2'b00;
         size_r       <= 2'b00;
         uns_r        <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_be       <= 4'd0;
         mem_wdata    <= 32'd0;
         if_valid     <= 1'b0;
         if_rdata     <= 32'd0;
         if_err       <= 1'b0;
         d_valid      <= 1'b0;
         d_rdata      <= 32'd0;
         d_err        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               starve_cnt_r <= starve_nxt_s;
               if (any_req_s) begin
                  win_data_r <= d_win_s;
                  ofs_r      <= sel_addr_s[1:0];
                  size_r     <= sel_size_s;
                  uns_r      <= d_win_s & d_unsigned;
                  mem_addr   <= {sel_addr_s[31:2], 2'b00};
                  mem_be     <= be_s;
                  mem_wdata  <= lane_wdata_s;
                  tmo_cnt_r  <= 8'd0;
                  if (misalign_s) begin
                     state_r  <= RESP;
                     d_valid  <= d_win_s;
                     d_err    <= d_win_s;
                     d_rdata  <= 32'd0;
                     if_valid <= ~d_win_s;
                     if_err   <= ~d_win_s;
                     if_rdata <= 32'd0;
                  end else begin
                     state_r <= GRANT;
                     mem_req <= 1'b1;
                     mem_we  <= sel_we_s;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            GRANT: begin
               if (mem_ready) begin
                  state_r <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (win_data_r) begin
                     d_valid <= 1'b1;
                     d_rdata <= resp_rdata_s;
                     d_err   <= 1'b0;
                  end else begin
                     if_valid <= 1'b1;
                     if_rdata <= resp_rdata_s;
                     if_err   <= 1'b0;
                  end
               end else if (tmo_cnt_r == TMO_LAST) begin
                  // Abort the stalled access and report it to whichever side owns it.
                  state_r  <= RESP;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  d_valid  <= win_data_r;
                  d_err    <= win_data_r;
                  d_rdata  <= 32'd0;
                  if_valid <= ~win_data_r;
                  if_err   <= ~win_data_r;
                  if_rdata <= 32'd0;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end
            end
            RESP: begin
               state_r  <= IDLE;
               if_valid <= 1'b0;
               if_err   <= 1'b0;
               if_rdata <= 32'd0;
               d_valid  <= 1'b0;
               d_err    <= 1'b0;
               d_rdata  <= 32'd0;
            end
            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end
endmodule
